dfm_gate_ctrl: RTL and testbench
================================

# dfm_gate_ctrl

Measurement sequencer for the digital frequency meter. It runs on the reference clock and generates the gate window that drives the gate-period counter. After the gate closes, it waits for the counter's 28-bit result to settle and reads it back with a double-sample stability check. It can optionally auto-range across four gate lengths before publishing a result with a one-cycle valid strobe.

## Interface
- GATE0, default 50_000: gate length in clk cycles, range 0 (1 ms at 50 MHz)
- GATE1, default 500_000: range 1 gate length
- GATE2, default 5_000_000: range 2 gate length
- GATE3, default 50_000_000: range 3 gate length (1 s)
- SETTLE, default 8: clk cycles waited after gate falls before sampling (≥2)
- LOW_THR, default 1000: auto-range under-count threshold
- HIGH_THR, default 200_000_000: auto-range over-count threshold (< 2^28)
- clk  in  1  reference clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request for one measurement
- cont  in  1  continuous mode; restart after each result while high
- auto_en  in  1  enable auto-ranging
- range_sel  in  2  manual range; used when auto_en=0
- cnt_in  in  28  count result from the gate-period counter
- gate  out  1  registered gate to the counter
- result  out  28  accepted count
- result_range  out  2  range used for `result`
- valid  out  1  one-cycle pulse when `result` updates
- busy  out  1  high from measurement launch until return to IDLE
- err  out  1  sticky readback failure; cleared by next accepted start

## Operation
- States: IDLE, GATE, SETTLE, SAMP0, SAMP1, EVAL, DONE.
- IDLE
  - On `start=1`, or `cont=1`, go to GATE.
  - Load the range: `range_sel` if `auto_en=0`, else the internal range register (reset 0, holds the last accepted range).
  - Clear `err`, the retry counter and the re-range counter.
- GATE: `gate=1` for exactly GATEn cycles (32-bit down-counter), then `gate=0` and go to SETTLE.
- SETTLE: wait SETTLE cycles, then go to SAMP0.
- SAMP0: capture `cnt_in` into s0.
- SAMP1: capture `cnt_in` into s1.
  - If s0==s1, go to EVAL.
  - Otherwise increment the retry counter and return to SAMP0.
  - On the 4th mismatch: set `err`, give no `valid`, go to IDLE. In continuous mode, relaunch from IDLE.
- EVAL (auto_en=1, re-range count < 3):
  - s1 < LOW_THR and range < 3: range+1, re-range count+1, back to GATE.
  - s1 > HIGH_THR, or s1==28'hFFFFFFF, and range > 0: range−1, re-range count+1, back to GATE.
  - Otherwise go to DONE.
  - With auto_en=0, or the re-range count at 3, go straight to DONE.
- DONE
  - `result<=s1`, `result_range<=range`, `valid=1` for this cycle.
  - If auto_en=1, store the range in the range register.
  - Then go to IDLE.
- `start` while busy is ignored. Dropping `cont` mid-measurement completes the current measurement, then the block stays in IDLE.
- `range_sel` changes take effect only at a launch from IDLE.
- Comparisons are unsigned, 28-bit.

## Timing
- Reset (async assert): gate=0, result=0, result_range=0, valid=0, busy=0, err=0, range register=0, state=IDLE. Deasserting reset mid-gate leaves the gate low, and the counter's partial count is discarded because no readback occurs.
- `start` sampled high at edge t gives gate=1 and busy=1 from t+1.
- Gate falls at t+1+GATEn.
- Earliest `valid` (no mismatch, no re-range) is at cycle t+1+GATEn+SETTLE+3.
- Each mismatch retry adds 2 cycles. Each re-range adds GATEn'+SETTLE+3 cycles.
- `busy` falls the cycle after `valid`.
- In continuous mode, the next gate rises 2 cycles after `valid`.
- The gate low time between measurements is ≥ SETTLE+4 cycles, which guarantees the counter sees a falling edge.

## Test plan
Parameters for all scenarios: GATE0=10, GATE1=100, GATE2=1000, GATE3=10000, SETTLE=4, LOW_THR=10, HIGH_THR=1000.

1. Manual range: auto_en=0, range_sel=1, start pulse, cnt_in held at 500 → gate high exactly 100 cycles; valid 1 cycle with result=500, result_range=1; busy low afterwards.
2. Auto up-range: auto_en=1, range reg 0, cnt_in=5 during range 0 then 50 → first EVAL goes to range 1, second gate is 100 cycles long; valid with result=50, result_range=1.
3. Auto down-range limit: cnt_in=28'hFFFFFFF always, range reg 3 → ranges 2, 1, 0 tried; after 3 re-ranges, valid with result=28'hFFFFFFF, result_range=0.
4. Unstable readback: cnt_in toggles every cycle → 4 mismatches; err=1, no valid, busy falls; a new start clears err.
5. Continuous mode and stray start: cont=1, cnt_in=500, range_sel=1 → back-to-back valids spaced 100+4+3+2 cycles apart; a start pulse asserted mid-gate has no effect; dropping cont after the 2nd valid produces no 3rd gate.
6. Reset mid-gate: rst_n=0 at cycle 50 of a 100-cycle gate → gate and busy go 0 immediately; no valid; range register=0.

Source files
------------

// File: rtl/dfm_gate_ctrl.sv
// dfm_gate_ctrl: measurement sequencer for the digital frequency meter.
// Opens a gate window of a range-dependent length, waits for the external
// counter to settle, reads its result twice until two samples agree, and
// optionally auto-ranges before publishing the count with a valid strobe.
module dfm_gate_ctrl #(
    parameter int unsigned GATE0    = 50_000,
    parameter int unsigned GATE1    = 500_000,
    parameter int unsigned GATE2    = 5_000_000,
    parameter int unsigned GATE3    = 50_000_000,
    parameter int unsigned SETTLE   = 8,
    parameter int unsigned LOW_THR  = 1000,
    parameter int unsigned HIGH_THR = 200_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont,
    input  logic        auto_en,
    input  logic [1:0]  range_sel,
    input  logic [27:0] cnt_in,
    output logic        gate,
    output logic [27:0] result,
    output logic [1:0]  result_range,
    output logic        valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_GATE, S_SETTLE, S_SAMP0, S_SAMP1, S_EVAL, S_DONE
    } state_t;

    localparam logic [27:0] LOW_T    = 28'(LOW_THR);
    localparam logic [27:0] HIGH_T   = 28'(HIGH_THR);
    localparam logic [31:0] SETTLE_M = 32'(SETTLE) - 32'd1;

    // Timer reload value for a gate of the given range (counts down to zero).
    function automatic logic [31:0] gate_load(input logic [1:0] r);
        logic [31:0] len;
        case (r)
            2'd0:    len = 32'(GATE0);
            2'd1:    len = 32'(GATE1);
            2'd2:    len = 32'(GATE2);
            default: len = 32'(GATE3);
        endcase
        return len - 32'd1;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] tmr_q, tmr_d;
    logic        gate_q, gate_d;
    logic [1:0]  range_q, range_d;         // range of the measurement in flight
    logic [1:0]  range_reg_q, range_reg_d; // last range accepted under auto-ranging
    logic [27:0] s0_q, s0_d;
    logic [27:0] s1_q, s1_d;
    logic [1:0]  retry_q, retry_d;
    logic [1:0]  rr_q, rr_d;
    logic [27:0] result_q, result_d;
    logic [1:0]  result_range_q, result_range_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    // Next-state logic; the result, range and valid are registered together on
    // entry to DONE so that valid is high exactly while the new result is shown.
    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        gate_d         = gate_q;
        range_d        = range_q;
        range_reg_d    = range_reg_q;
        s0_d           = s0_q;
        s1_d           = s1_q;
        retry_d        = retry_q;
        rr_d           = rr_q;
        result_d       = result_q;
        result_range_d = result_range_q;
        valid_d        = 1'b0;
        err_d          = err_q;

        case (state_q)
            S_IDLE: begin
                if (start || cont) begin
                    range_d = auto_en ? range_reg_q : range_sel;
                    tmr_d   = gate_load(auto_en ? range_reg_q : range_sel);
                    gate_d  = 1'b1;
                    err_d   = 1'b0;
                    retry_d = 2'd0;
                    rr_d    = 2'd0;
                    state_d = S_GATE;
                end
            end
            S_GATE: begin
                if (tmr_q == 32'd0) begin
                    gate_d  = 1'b0;
                    tmr_d   = SETTLE_M;
                    state_d = S_SETTLE;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end
            S_SETTLE: begin
                if (tmr_q == 32'd0) begin
                    state_d = S_SAMP0;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end
            S_SAMP0: begin
                s0_d    = cnt_in;
                state_d = S_SAMP1;
            end
            S_SAMP1: begin
                s1_d = cnt_in;
                if (cnt_in == s0_q) begin
                    state_d = S_EVAL;
                end else if (retry_q == 2'd3) begin
                    // Fourth disagreement: give up on this reading without valid.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    retry_d = retry_q + 2'd1;
                    state_d = S_SAMP0;
                end
            end
            S_EVAL: begin
                if (auto_en && rr_q != 2'd3 && s1_q < LOW_T && range_q != 2'd3) begin
                    range_d = range_q + 2'd1;
                    tmr_d   = gate_load(range_q + 2'd1);
                    gate_d  = 1'b1;
                    rr_d    = rr_q + 2'd1;
                    state_d = S_GATE;
                end else if (auto_en && rr_q != 2'd3 && (s1_q > HIGH_T || s1_q == '1)
                             && range_q != 2'd0) begin
                    range_d = range_q - 2'd1;
                    tmr_d   = gate_load(range_q - 2'd1);
                    gate_d  = 1'b1;
                    rr_d    = rr_q + 2'd1;
                    state_d = S_GATE;
                end else begin
                    result_d       = s1_q;
                    result_range_d = range_q;
                    valid_d        = 1'b1;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                if (auto_en) begin
                    range_reg_d = range_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                gate_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any measurement in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            tmr_q          <= 32'd0;
            gate_q         <= 1'b0;
            range_q        <= 2'd0;
            range_reg_q    <= 2'd0;
            s0_q           <= 28'd0;
            s1_q           <= 28'd0;
            retry_q        <= 2'd0;
            rr_q           <= 2'd0;
            result_q       <= 28'd0;
            result_range_q <= 2'd0;
            valid_q        <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            gate_q         <= gate_d;
            range_q        <= range_d;
            range_reg_q    <= range_reg_d;
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            retry_q        <= retry_d;
            rr_q           <= rr_d;
            result_q       <= result_d;
            result_range_q <= result_range_d;
            valid_q        <= valid_d;
            err_q          <= err_d;
        end
    end

    assign gate         = gate_q;
    assign result       = result_q;
    assign result_range = result_range_q;
    assign valid        = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;

endmodule

// File: tb/tb_dfm_gate_ctrl.sv
// Directed bench for dfm_gate_ctrl using small gate lengths.
module tb_dfm_gate_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cont;
    logic        auto_en;
    logic [1:0]  range_sel;
    logic [27:0] cnt_in;
    logic        gate;
    logic [27:0] result;
    logic [1:0]  result_range;
    logic        valid;
    logic        busy;
    logic        err;

    int total;
    int bad;

    // cnt_in source: 0 = constant lo, 1 = toggle lo/hi every cycle,
    // 2 = lo until the second gate of a measurement rises, then hi.
    int          cmode;
    logic [27:0] cval_lo;
    logic [27:0] cval_hi;

    dfm_gate_ctrl #(
        .GATE0(10), .GATE1(100), .GATE2(1000), .GATE3(10000),
        .SETTLE(4), .LOW_THR(10), .HIGH_THR(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
        .auto_en(auto_en), .range_sel(range_sel), .cnt_in(cnt_in),
        .gate(gate), .result(result), .result_range(result_range),
        .valid(valid), .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counter model driving cnt_in, updated away from the active edge.
    initial begin
        int   rises;
        int   lastm;
        logic pg;
        rises  = 0;
        lastm  = -1;
        pg     = 1'b0;
        cnt_in = 28'd0;
        forever begin
            @(negedge clk);
            if (cmode != lastm) begin
                rises = 0;
                lastm = cmode;
            end
            if (gate && !pg) rises++;
            pg = gate;
            case (cmode)
                1:       cnt_in = (cnt_in == cval_lo) ? cval_hi : cval_lo;
                2:       cnt_in = (rises >= 2) ? cval_hi : cval_lo;
                default: cnt_in = cval_lo;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Launch one measurement with a start pulse and observe it until busy drops.
    task automatic run_meas(input string tag, input int limit, output int gcyc,
                            output int lat, output int nv,
                            output logic [27:0] res, output logic [1:0] rr);
        gcyc = 0;
        lat  = -1;
        nv   = 0;
        res  = 28'd0;
        rr   = 2'd0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (gate) gcyc++;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (gate) gcyc++;
            if (valid) begin
                nv++;
                if (lat < 0) lat = k;
                res = result;
                rr  = result_range;
            end
            if (!busy) break;
        end
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          gcyc, lat, nv;
        logic [27:0] res;
        logic [1:0]  rr;
        total     = 0;
        bad       = 0;
        cmode     = 0;
        cval_lo   = 28'd0;
        cval_hi   = 28'd0;
        rst_n     = 1'b0;
        start     = 1'b0;
        cont      = 1'b0;
        auto_en   = 1'b0;
        range_sel = 2'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_range", 32'(result_range), 32'd0);
        rst_n = 1'b1;

        // 1: manual range 1, stable count 500
        auto_en = 1'b0; range_sel = 2'd1; cmode = 0; cval_lo = 28'd500;
        run_meas("t1", 500, gcyc, lat, nv, res, rr);
        chk("t1_gate_len", 32'(gcyc), 32'd100);
        chk("t1_latency", 32'(lat), 32'd107);
        chk("t1_nvalid", 32'(nv), 32'd1);
        chk("t1_result", 32'(res), 32'd500);
        chk("t1_range", 32'(rr), 32'd1);
        chk("t1_err", 32'(err), 32'd0);

        // 2: auto up-range from range 0: count 5 then 50
        auto_en = 1'b1; range_sel = 2'd3; cmode = 2; cval_lo = 28'd5; cval_hi = 28'd50;
        run_meas("t2", 500, gcyc, lat, nv, res, rr);
        chk("t2_gate_total", 32'(gcyc), 32'd110);
        chk("t2_latency", 32'(lat), 32'd124);
        chk("t2_nvalid", 32'(nv), 32'd1);
        chk("t2_result", 32'(res), 32'd50);
        chk("t2_range", 32'(rr), 32'd1);

        // 6: reset in the middle of a 100-cycle gate
        auto_en = 1'b0; range_sel = 2'd1; cmode = 0; cval_lo = 28'd500;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        chk("t6_gate_before", 32'(gate), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_gate_async", 32'(gate), 32'd0);
        chk("t6_busy_async", 32'(busy), 32'd0);
        chk("t6_valid_async", 32'(valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0; gcyc = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (valid) nv++;
            if (gate) gcyc++;
        end
        chk("t6_no_valid", 32'(nv), 32'd0);
        chk("t6_no_gate", 32'(gcyc), 32'd0);
        auto_en = 1'b1;
        run_meas("t6b", 500, gcyc, lat, nv, res, rr);
        chk("t6_range_reg", 32'(rr), 32'd0);
        chk("t6_gate_len", 32'(gcyc), 32'd10);
        chk("t6_result", 32'(res), 32'd500);

        // Drive the range register to 3 with a persistently low count
        auto_en = 1'b1; cmode = 0; cval_lo = 28'd5;
        run_meas("prep", 12000, gcyc, lat, nv, res, rr);
        chk("prep_gate_total", 32'(gcyc), 32'd11110);
        chk("prep_range", 32'(rr), 32'd3);
        chk("prep_result", 32'(res), 32'd5);

        // 3: saturated count walks the range down to 0
        cval_lo = 28'hFFFFFFF;
        run_meas("t3", 12000, gcyc, lat, nv, res, rr);
        chk("t3_gate_total", 32'(gcyc), 32'd11110);
        chk("t3_latency", 32'(lat), 32'd11138);
        chk("t3_result", 32'(res), 32'h0FFFFFFF);
        chk("t3_range", 32'(rr), 32'd0);

        // 4: unstable readback, then a clean start clears err
        auto_en = 1'b0; range_sel = 2'd0; cmode = 1; cval_lo = 28'd5; cval_hi = 28'd10;
        run_meas("t4", 200, gcyc, lat, nv, res, rr);
        chk("t4_nvalid", 32'(nv), 32'd0);
        chk("t4_err", 32'(err), 32'd1);
        cmode = 0; cval_lo = 28'd77;
        run_meas("t4b", 200, gcyc, lat, nv, res, rr);
        chk("t4_err_cleared", 32'(err), 32'd0);
        chk("t4b_nvalid", 32'(nv), 32'd1);
        chk("t4b_result", 32'(res), 32'd77);

        // 5: continuous mode with a stray start during the first gate
        begin
            int   v1, v2, glen, rises_after, nvc;
            logic pg;
            v1 = -1; v2 = -1; glen = 0; rises_after = 0; nvc = 0; pg = 1'b0;
            auto_en = 1'b0; range_sel = 2'd1; cmode = 0; cval_lo = 28'd500;
            repeat (2) @(negedge clk);
            cont = 1'b1;
            for (int k = 1; k <= 500; k++) begin
                @(negedge clk);
                start = (k == 30);
                if (valid) begin
                    nvc++;
                    res = result;
                    rr  = result_range;
                    if (v1 < 0) v1 = k;
                    else if (v2 < 0) begin
                        v2   = k;
                        cont = 1'b0;
                    end
                end
                if (v1 < 0 && gate) glen++;
                if (v2 >= 0 && k > v2 && gate && !pg) rises_after++;
                pg = gate;
            end
            start = 1'b0;
            chk("t5_gate_len", 32'(glen), 32'd100);
            chk("t5_spacing", 32'(v2 - v1), 32'd109);
            chk("t5_nvalid", 32'(nvc), 32'd2);
            chk("t5_result", 32'(res), 32'd500);
            chk("t5_range", 32'(rr), 32'd1);
            chk("t5_no_third_gate", 32'(rises_after), 32'd0);
            chk("t5_busy_end", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
